// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART receiver.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 10416;
    localparam int CNT_W                = 14;

    typedef enum logic [2:0] {
        s_IDLE   = 3'd0,
        s_START  = 3'd1,
        s_DATA   = 3'd2,
        s_PARITY = 3'd3,
        s_STOP   = 3'd4,
        s_BREAK  = 3'd5
    } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line in, received byte and status pulses out.
interface uart_rx_if;

    logic       i_SERIAL;
    logic [7:0] o_BYTE;
    logic       o_DV;
    logic       o_FRAME_ERR;
    logic       o_PARITY_ERR;
    logic       o_BUSY;

    modport master (
        output i_SERIAL,
        input  o_BYTE, o_DV, o_FRAME_ERR, o_PARITY_ERR, o_BUSY
    );

    modport slave (
        input  i_SERIAL,
        output o_BYTE, o_DV, o_FRAME_ERR, o_PARITY_ERR, o_BUSY
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line; presets to idle-high while in reset.
module uart_rx_sync (
    input  logic i_CLK,
    input  logic i_RST_N,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits, mid-bit sampling, frame-error break handling.
// Define UART_RX_PARITY_EN for an even-parity bit after D7 (8E1); default is 8N1.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic     i_CLK,
    input  logic     i_RST_N,
    uart_rx_if.slave rx
);

    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] MID_TICK  = CNT_W'((CLKS_PER_BIT - 1) / 2);

    rx_state_e        state;
    logic             rx_bit;
    logic [CNT_W-1:0] t_CLK;
    logic [2:0]       t_INDEX;
    logic [7:0]       shift_reg;
    logic [7:0]       byte_q;
    logic             dv_q;
    logic             ferr_q;
    logic [1:0]       warm_cnt;
    logic             armed;
`ifdef UART_RX_PARITY_EN
    logic             parity_bit;
    logic             perr_q;
`endif

    uart_rx_sync u_sync (
        .i_CLK   (i_CLK),
        .i_RST_N (i_RST_N),
        .d       (rx.i_SERIAL),
        .q       (rx_bit)
    );

    // The synchronizer reads high straight after reset, so the line only counts as
    // seen-idle once real pin data has flushed through; a frame caught mid-flight is skipped.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            warm_cnt <= 2'd0;
            armed    <= 1'b0;
        end else begin
            if (warm_cnt != 2'd3)
                warm_cnt <= warm_cnt + 2'd1;
            if (warm_cnt == 2'd3 && rx_bit)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state     <= s_IDLE;
            t_CLK     <= '0;
            t_INDEX   <= 3'd0;
            shift_reg <= 8'h00;
            byte_q    <= 8'h00;
            dv_q      <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            dv_q   <= 1'b0;
            ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q <= 1'b0;
`endif
            case (state)
                s_IDLE: begin
                    if (armed && !rx_bit) begin
                        t_CLK   <= '0;
                        t_INDEX <= 3'd0;
                        state   <= s_START;
                    end
                end
                s_START: begin
                    if (t_CLK == MID_TICK) begin
                        t_CLK <= '0;
                        state <= rx_bit ? s_IDLE : s_DATA;
                    end else begin
                        t_CLK <= t_CLK + 1'b1;
                    end
                end
                s_DATA: begin
                    if (t_CLK == LAST_TICK) begin
                        t_CLK              <= '0;
                        shift_reg[t_INDEX] <= rx_bit;
                        t_INDEX            <= t_INDEX + 3'd1;
                        if (t_INDEX == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= s_PARITY;
`else
                            state <= s_STOP;
`endif
                        end
                    end else begin
                        t_CLK <= t_CLK + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                s_PARITY: begin
                    if (t_CLK == LAST_TICK) begin
                        t_CLK      <= '0;
                        parity_bit <= rx_bit;
                        state      <= s_STOP;
                    end else begin
                        t_CLK <= t_CLK + 1'b1;
                    end
                end
`endif
                s_STOP: begin
                    if (t_CLK == LAST_TICK) begin
                        t_CLK <= '0;
                        if (!rx_bit) begin
                            ferr_q <= 1'b1;
                            state  <= s_BREAK;
`ifdef UART_RX_PARITY_EN
                        end else if (parity_bit != ^shift_reg) begin
                            perr_q <= 1'b1;
                            state  <= s_IDLE;
`endif
                        end else begin
                            byte_q <= shift_reg;
                            dv_q   <= 1'b1;
                            state  <= s_IDLE;
                        end
                    end else begin
                        t_CLK <= t_CLK + 1'b1;
                    end
                end
                s_BREAK: begin
                    if (rx_bit)
                        state <= s_IDLE;
                end
                default: state <= s_IDLE;
            endcase
        end
    end

    assign rx.o_BYTE      = byte_q;
    assign rx.o_DV        = dv_q;
    assign rx.o_FRAME_ERR = ferr_q;
    assign rx.o_BUSY      = (state != s_IDLE);
`ifdef UART_RX_PARITY_EN
    assign rx.o_PARITY_ERR = perr_q;
`else
    assign rx.o_PARITY_ERR = 1'b0;
`endif

endmodule
